fsm_status_monitor: RTL and testbench

//   Consumer of the 8-bit LED/status code bus driven by the sequence FSM: IDLE=0, COUNT=10, WAIT=5, DONE=15.

---
 rtl/fsm_status_monitor.sv | 215 +++++++++++++++++++++
 tb/tb_fsm_status_monitor.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_status_monitor.sv
// -----------------------------------------------------------------------------
// fsm_status_monitor
//
// Watches the 8-bit status code bus of a neighbouring sequence FSM
// (IDLE=0x00, COUNT=0x0A, WAIT=0x05, DONE=0x0F). The bus is deglitched, the
// accepted codes are tracked against the legal order
// IDLE -> COUNT -> WAIT -> DONE -> IDLE, and sticky flags report unknown
// codes, out-of-order codes and states that dwell too long. Completed
// sequences and the length of the last COUNT phase are reported.
//
// Parameters
//   STABLE_CYCLES  identical consecutive samples needed to accept a code (1..15)
//   TIMEOUT        cycles allowed in a non-IDLE tracked state without a change
//
// Ports
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   status_in  in   8  observed status code bus
//   err_clear  in   1  pulse; clears err_code, err_order and timeout
//   state_o    out  3  tracked state (0 idle, 1 count, 2 wait, 3 done, 4 err)
//   seq_done   out  1  one-cycle pulse on a legal DONE->IDLE
//   seq_count  out  8  completed sequences, wrapping
//   count_len  out  8  cycles in COUNT during the last sequence, saturating
//   err_code   out  1  sticky: accepted code outside the legal set
//   err_order  out  1  sticky: legal code accepted out of order
//   timeout    out  1  sticky: dwell limit reached
//
// State table
//   state    | meaning
//   ST_IDLE  | sequence idle, waiting for COUNT code
//   ST_COUNT | COUNT phase, measuring its length
//   ST_WAIT  | WAIT phase, expecting DONE code
//   ST_DONE  | DONE phase, expecting return to IDLE
//   ST_ERR   | protocol error seen; only code 0x00 leaves
// -----------------------------------------------------------------------------
module fsm_status_monitor #(
    parameter int unsigned STABLE_CYCLES = 2,
    parameter logic [23:0] TIMEOUT       = 24'd10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] status_in,
    input  logic       err_clear,
    output logic [2:0] state_o,
    output logic       seq_done,
    output logic [7:0] seq_count,
    output logic [7:0] count_len,
    output logic       err_code,
    output logic       err_order,
    output logic       timeout
);

    localparam logic [7:0] CODE_IDLE  = 8'h00;
    localparam logic [7:0] CODE_COUNT = 8'h0A;
    localparam logic [7:0] CODE_WAIT  = 8'h05;
    localparam logic [7:0] CODE_DONE  = 8'h0F;

    localparam logic [3:0] STAB_MAX = 4'(STABLE_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    state_t      state_q;
    state_t      state_d;
    state_t      next_state;
    logic [7:0]  last_q;
    logic [3:0]  stab_q;
    logic [3:0]  stab_d;
    logic        same;
    logic        accept;
    logic [7:0]  own_code;
    logic [7:0]  next_code;
    logic        is_legal;
    logic        set_code;
    logic        set_order;
    logic        done_d;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_inc;
    logic [23:0] dwell_q;
    logic        dwell_clr;
    logic        tmo_hit;

    // Deglitch: a code is accepted only on the edge its run length reaches
    // STAB_MAX; once saturated, further identical samples do not re-accept.
    always_comb begin
        same   = (status_in == last_q);
        stab_d = 4'd1;
        accept = 1'b0;
        if (same) begin
            stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + 4'd1;
            accept = (stab_q == STAB_MAX - 4'd1);
        end else begin
            accept = (STAB_MAX == 4'd1);
        end
    end

    always_comb begin
        own_code   = CODE_IDLE;
        next_code  = CODE_COUNT;
        next_state = ST_COUNT;
        case (state_q)
            ST_IDLE: begin
                own_code   = CODE_IDLE;
                next_code  = CODE_COUNT;
                next_state = ST_COUNT;
            end
            ST_COUNT: begin
                own_code   = CODE_COUNT;
                next_code  = CODE_WAIT;
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                own_code   = CODE_WAIT;
                next_code  = CODE_DONE;
                next_state = ST_DONE;
            end
            ST_DONE: begin
                own_code   = CODE_DONE;
                next_code  = CODE_IDLE;
                next_state = ST_IDLE;
            end
            default: begin
                own_code   = CODE_IDLE;
                next_code  = CODE_COUNT;
                next_state = ST_COUNT;
            end
        endcase
    end

    assign is_legal = (status_in == CODE_IDLE) || (status_in == CODE_COUNT) ||
                      (status_in == CODE_WAIT) || (status_in == CODE_DONE);

    always_comb begin
        state_d   = state_q;
        set_code  = 1'b0;
        set_order = 1'b0;
        done_d    = 1'b0;
        if (accept) begin
            if (state_q == ST_ERR) begin
                if (status_in == CODE_IDLE) begin
                    state_d = ST_IDLE;
                end
            end else if (!is_legal) begin
                state_d  = ST_ERR;
                set_code = 1'b1;
            end else if (status_in == next_code) begin
                state_d = next_state;
                done_d  = (state_q == ST_DONE);
            end else if (status_in != own_code) begin
                state_d   = ST_ERR;
                set_order = 1'b1;
            end
        end
    end

    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    // Dwell timer is a down-counter reloaded with TIMEOUT; the terminal count
    // fires on the edge it steps from 1 to 0 and then it parks at 0.
    assign dwell_clr = (state_q == ST_IDLE) || (state_d != state_q);
    assign tmo_hit   = !dwell_clr && (dwell_q == 24'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            last_q    <= 8'h00;
            stab_q    <= 4'd0;
            cnt_q     <= 8'd0;
            dwell_q   <= TIMEOUT;
            state_o   <= 3'd0;
            seq_done  <= 1'b0;
            seq_count <= 8'd0;
            count_len <= 8'd0;
            err_code  <= 1'b0;
            err_order <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            last_q  <= status_in;
            stab_q  <= stab_d;
            state_q <= state_d;
            state_o <= state_d;

            if (state_q == ST_COUNT) begin
                cnt_q <= cnt_inc;
            end
            if ((state_d == ST_COUNT) && (state_q != ST_COUNT)) begin
                cnt_q <= 8'd0;
            end
            // The exit edge itself is a COUNT cycle, hence the incremented copy.
            if ((state_q == ST_COUNT) && (state_d == ST_WAIT)) begin
                count_len <= cnt_inc;
            end

            if (dwell_clr) begin
                dwell_q <= TIMEOUT;
            end else if (dwell_q != 24'd0) begin
                dwell_q <= dwell_q - 24'd1;
            end

            seq_done  <= done_d;
            seq_count <= seq_count + 8'(done_d);

            // Setting a flag takes priority over a coincident clear.
            err_code  <= set_code  | (err_code  & ~err_clear);
            err_order <= set_order | (err_order & ~err_clear);
            timeout   <= tmo_hit   | (timeout   & ~err_clear);
        end
    end

endmodule

// File: tb/tb_fsm_status_monitor.sv
// -----------------------------------------------------------------------------
// tb_fsm_status_monitor
//
// Directed scenarios followed by random code runs. A behavioural model tracks
// run lengths of the sampled bus, the position of the tracker within the
// legal code cycle, and plain integer cycle counts for COUNT length and dwell.
// -----------------------------------------------------------------------------
module tb_fsm_status_monitor;

    localparam int STABLE = 2;
    localparam int TMO    = 8;

    logic       clk;
    logic       rst_n;
    logic [7:0] status_in;
    logic       err_clear;
    logic [2:0] state_o;
    logic       seq_done;
    logic [7:0] seq_count;
    logic [7:0] count_len;
    logic       err_code;
    logic       err_order;
    logic       timeout;

    fsm_status_monitor #(
        .STABLE_CYCLES(STABLE),
        .TIMEOUT      (24'(TMO))
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .status_in(status_in),
        .err_clear(err_clear),
        .state_o  (state_o),
        .seq_done (seq_done),
        .seq_count(seq_count),
        .count_len(count_len),
        .err_code (err_code),
        .err_order(err_order),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model
    int         run_len;
    logic [7:0] prev_s;
    int         m_state;
    int         m_seq_count;
    int         m_count_len;
    int         m_in_count;
    int         m_dwell;
    bit         m_seq_done;
    bit         m_err_code;
    bit         m_err_order;
    bit         m_timeout;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Legal cycle 0x00,0x0A,0x05,0x0F; tracker state equals position in it.
    function automatic int code_pos(input logic [7:0] c);
        case (c)
            8'h00:   return 0;
            8'h0A:   return 1;
            8'h05:   return 2;
            8'h0F:   return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] pos_code(input int p);
        case (p)
            0:       return 8'h00;
            1:       return 8'h0A;
            2:       return 8'h05;
            default: return 8'h0F;
        endcase
    endfunction

    task automatic model_reset();
        run_len     = 0;
        prev_s      = 8'h00;
        m_state     = 0;
        m_seq_count = 0;
        m_count_len = 0;
        m_in_count  = 0;
        m_dwell     = 0;
        m_seq_done  = 0;
        m_err_code  = 0;
        m_err_order = 0;
        m_timeout   = 0;
    endtask

    task automatic model_edge(input logic [7:0] s, input bit clr);
        int  old_st;
        int  nxt;
        int  pos;
        bit  set_c;
        bit  set_o;
        bit  set_t;
        bit  done;
        if (run_len > 0 && s == prev_s) run_len++;
        else run_len = 1;
        prev_s = s;

        old_st = m_state;
        nxt    = old_st;
        set_c  = 0;
        set_o  = 0;
        set_t  = 0;
        done   = 0;
        if (run_len == STABLE) begin
            pos = code_pos(s);
            if (old_st == 4) begin
                if (pos == 0) nxt = 0;
            end else if (pos < 0) begin
                nxt   = 4;
                set_c = 1;
            end else if (pos == (old_st + 1) % 4) begin
                nxt  = pos;
                done = (old_st == 3);
            end else if (pos != old_st) begin
                nxt   = 4;
                set_o = 1;
            end
        end

        if (old_st == 1) m_in_count++;
        if (old_st == 1 && nxt == 2) m_count_len = (m_in_count > 255) ? 255 : m_in_count;
        if (nxt == 1 && old_st != 1) m_in_count = 0;

        if (nxt != old_st || old_st == 0) begin
            m_dwell = 0;
        end else begin
            m_dwell++;
            if (m_dwell == TMO) set_t = 1;
        end

        m_err_code  = set_c | (m_err_code  & !clr);
        m_err_order = set_o | (m_err_order & !clr);
        m_timeout   = set_t | (m_timeout   & !clr);
        m_seq_done  = done;
        if (done) m_seq_count = (m_seq_count + 1) % 256;
        m_state = nxt;
    endtask

    task automatic compare_all();
        check_val("state_o",   int'(state_o),   m_state);
        check_val("seq_done",  int'(seq_done),  int'(m_seq_done));
        check_val("seq_count", int'(seq_count), m_seq_count);
        check_val("count_len", int'(count_len), m_count_len);
        check_val("err_code",  int'(err_code),  int'(m_err_code));
        check_val("err_order", int'(err_order), int'(m_err_order));
        check_val("timeout",   int'(timeout),   int'(m_timeout));
    endtask

    task automatic step(input logic [7:0] s, input bit clr);
        @(negedge clk);
        status_in = s;
        err_clear = clr;
        @(posedge clk);
        model_edge(s, clr);
        #1;
        compare_all();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_state"}, int'(state_o), 0);
        check_val({tag, "_flags"}, int'({seq_done, err_code, err_order, timeout}), 0);
        check_val({tag, "_cnt"},   int'({seq_count, count_len}), 0);
    endtask

    logic [7:0] leg_c [18] = '{8'h00, 8'h00, 8'h00, 8'h00,
                               8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A,
                               8'h05, 8'h05, 8'h05,
                               8'h0F, 8'h0F, 8'h0F,
                               8'h00, 8'h00, 8'h00};
    int         leg_s [18] = '{0, 0, 0, 0,
                               0, 1, 1, 1, 1,
                               1, 2, 2,
                               2, 3, 3,
                               3, 0, 0};

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int         pulses;
        int         r;
        int         len;
        logic [7:0] code;
        logic [7:0] last_code;

        rst_n     = 1'b0;
        status_in = 8'h00;
        err_clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Legal sequence
        pulses = 0;
        for (int i = 0; i < 18; i++) begin
            step(leg_c[i], 1'b0);
            check_val("legal_state", int'(state_o), leg_s[i]);
            pulses += int'(seq_done);
        end
        check_val("legal_pulses", pulses, 1);
        check_val("legal_seq_count", int'(seq_count), 1);
        check_val("legal_count_len", int'(count_len), 5);
        check_val("legal_flags", int'({err_code, err_order, timeout}), 0);

        // Single-cycle glitch in IDLE
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        step(8'h0A, 1'b0);
        check_val("glitch_state", int'(state_o), 0);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        check_val("glitch_state2", int'(state_o), 0);
        check_val("glitch_flags", int'({err_code, err_order}), 0);

        // Unknown code from COUNT
        step(8'h0A, 1'b0);
        step(8'h0A, 1'b0);
        check_val("bad_in_count", int'(state_o), 1);
        step(8'h11, 1'b0);
        step(8'h11, 1'b0);
        check_val("bad_state", int'(state_o), 4);
        check_val("bad_err_code", int'(err_code), 1);
        step(8'h0F, 1'b0);
        step(8'h0F, 1'b0);
        check_val("bad_stuck_err", int'(state_o), 4);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        check_val("bad_exit", int'(state_o), 0);
        check_val("bad_code_kept", int'(err_code), 1);
        step(8'h00, 1'b1);
        check_val("bad_cleared", int'(err_code), 0);

        // Out-of-order code from IDLE
        step(8'h05, 1'b0);
        step(8'h05, 1'b0);
        check_val("order_state", int'(state_o), 4);
        check_val("order_flag", int'(err_order), 1);
        check_val("order_no_code", int'(err_code), 0);
        check_val("order_seq_count", int'(seq_count), 1);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        step(8'h00, 1'b1);

        // Dwell timeout in COUNT, clear coincident with the setting edge
        for (int i = 1; i <= 20; i++) begin
            step(8'h0A, (i == 10));
            if (i >= 2) check_val("tmo_state", int'(state_o), 1);
            check_val("tmo_flag", int'(timeout), (i >= 10) ? 1 : 0);
        end

        // Asynchronous reset in WAIT
        step(8'h05, 1'b0);
        step(8'h05, 1'b0);
        check_val("rst_pre_wait", int'(state_o), 2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        check_all_zero("held_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h0F, 1'b0);
        step(8'h0F, 1'b0);
        check_val("post_rst_state", int'(state_o), 4);
        check_val("post_rst_order", int'(err_order), 1);

        // Random runs
        last_code = 8'h0F;
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 15);
            if (r <= 8)       code = pos_code((m_state == 4) ? 0 : (m_state + 1) % 4);
            else if (r <= 11) code = pos_code($urandom_range(0, 3));
            else if (r <= 13) code = 8'($urandom_range(0, 255));
            else              code = last_code;
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 12) : $urandom_range(1, 3);
            for (int k = 0; k < len; k++) begin
                step(code, ($urandom_range(0, 9) == 0));
            end
            last_code = code;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
